// File: rtl/gpio_hub.sv
// Wishbone-slave GPIO: atomic set/clear/toggle outputs, synchronised and debounced
// inputs with masked rising/falling edge capture ORed into a level interrupt.
module gpio_hub #(
   parameter int unsigned         WIDTH     = 32,
   parameter int unsigned         GPO_BITS  = 16,
   parameter int unsigned         GPI_BITS  = 4,
   parameter int unsigned         BASE      = 24,
   parameter int unsigned         TICK_BITS = 16,
   parameter logic [GPO_BITS-1:0] GPO_INIT  = '0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [14:0]         adr_i,
   input  logic [WIDTH-1:0]    dat_i,
   output logic [WIDTH-1:0]    dat_o,
   input  logic                we_i,
   input  logic                stb_i,
   output logic                ack_o,
   output logic [GPO_BITS-1:0] gp_o,
   input  logic [GPI_BITS-1:0] gp_i,
   output logic                irq_o
);

   typedef enum logic [2:0] {
      R_GPO  = 3'd0,
      R_SET  = 3'd1,
      R_CLR  = 3'd2,
      R_TGL  = 3'd3,
      R_GPI  = 3'd4,
      R_PEND = 3'd5,
      R_REN  = 3'd6,
      R_FEN  = 3'd7
   } reg_e;

   localparam logic [11:0] WIN = 12'(BASE >> 3);

   logic                 sel, acc, wr;
   reg_e                 idx;
   logic [GPO_BITS-1:0]  gpo, wd_o;
   logic [GPI_BITS-1:0]  wd_i, rise_en, fall_en, pend, w1c, rise, fall;
   logic [GPI_BITS-1:0]  sync1, sync2, samp, deb, deb_q, agree;
   logic [TICK_BITS-1:0] cnt;
   logic                 tick;
   logic [WIDTH-1:0]     rdata;
   logic                 unused_dat;

   assign sel  = (adr_i[14:3] == WIN);
   assign acc  = stb_i & sel & ~ack_o;
   assign wr   = acc & we_i;
   assign idx  = reg_e'(adr_i[2:0]);
   assign wd_o = dat_i[GPO_BITS-1:0];
   assign wd_i = dat_i[GPI_BITS-1:0];
   assign gp_o = gpo;
   assign unused_dat = ^dat_i;

   always_comb begin
      rdata = '0;
      case (idx)
         R_GPO, R_SET, R_CLR, R_TGL: rdata[GPO_BITS-1:0] = gpo;
         R_GPI:  rdata[GPI_BITS-1:0] = deb;
         R_PEND: rdata[GPI_BITS-1:0] = pend;
         R_REN:  rdata[GPI_BITS-1:0] = rise_en;
         R_FEN:  rdata[GPI_BITS-1:0] = fall_en;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack_o   <= 1'b0;
         dat_o   <= '0;
         gpo     <= GPO_INIT;
         rise_en <= '0;
         fall_en <= '0;
      end else begin
         ack_o <= acc;
         if (acc && !we_i)
            dat_o <= rdata;
         if (wr) begin
            case (idx)
               R_GPO:  gpo     <= wd_o;
               R_SET:  gpo     <= gpo | wd_o;
               R_CLR:  gpo     <= gpo & ~wd_o;
               R_TGL:  gpo     <= gpo ^ wd_o;
               R_REN:  rise_en <= wd_i;
               R_FEN:  fall_en <= wd_i;
               default: ;
            endcase
         end
      end
   end

   // deb only follows bits whose sample matched on two consecutive ticks
   assign tick  = &cnt;
   assign agree = ~(samp ^ sync2);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
         samp  <= '0;
         deb   <= '0;
         deb_q <= '0;
         cnt   <= '0;
      end else begin
         sync1 <= gp_i;
         sync2 <= sync1;
         cnt   <= cnt + TICK_BITS'(1);
         deb_q <= deb;
         if (tick) begin
            samp <= sync2;
            deb  <= (deb & ~agree) | (samp & agree);
         end
      end
   end

   // a new edge outranks a simultaneous write-1-to-clear
   assign w1c  = (wr && idx == R_PEND) ? wd_i : '0;
   assign rise = deb & ~deb_q & rise_en;
   assign fall = ~deb & deb_q & fall_en;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend  <= '0;
         irq_o <= 1'b0;
      end else begin
         pend  <= (pend & ~w1c) | rise | fall;
         irq_o <= |pend;
      end
   end

endmodule

// File: tb/tb_gpio_hub.sv
// Bench for gpio_hub: directed scenarios with literal expectations plus randomized
// bus/input traffic, all checked every cycle against a behavioural model.
module tb_gpio_hub;

   localparam int unsigned WIDTH     = 32;
   localparam int unsigned GPO_BITS  = 16;
   localparam int unsigned GPI_BITS  = 4;
   localparam int unsigned BASE      = 24;
   localparam int unsigned TICK_BITS = 2;
   localparam int unsigned TP        = 1 << TICK_BITS;
   localparam logic [15:0] INIT      = 16'hA5C3;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic [14:0] adr   = '0;
   logic [31:0] dat_i = '0;
   logic [31:0] dat_o;
   logic        we    = 1'b0;
   logic        stb   = 1'b0;
   logic        ack;
   logic [15:0] gp_o;
   logic [3:0]  gp_i  = '0;
   logic        irq;

   int tests = 0;
   int fails = 0;

   gpio_hub #(
      .WIDTH(WIDTH), .GPO_BITS(GPO_BITS), .GPI_BITS(GPI_BITS),
      .BASE(BASE), .TICK_BITS(TICK_BITS), .GPO_INIT(INIT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .adr_i(adr), .dat_i(dat_i), .dat_o(dat_o),
      .we_i(we), .stb_i(stb), .ack_o(ack), .gp_o(gp_o), .gp_i(gp_i), .irq_o(irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: state after each rising edge
   logic [15:0] m_gpo;
   logic [3:0]  m_ren, m_fen, m_pend, m_deb, m_debq, m_last_tick, h1, h2;
   logic        m_ack, m_irq;
   logic [31:0] m_dat;
   int unsigned n_clk;

   always @(posedge clk) begin : model
      logic [3:0]  sync_now, n_deb, w1c, rise, fall;
      logic        acc;
      logic [2:0]  ri;
      if (!rst_n) begin
         m_gpo = INIT; m_ren = '0; m_fen = '0; m_pend = '0; m_deb = '0; m_debq = '0;
         m_last_tick = '0; h1 = '0; h2 = '0; m_ack = 1'b0; m_irq = 1'b0; m_dat = '0;
         n_clk = 0;
      end else begin
         sync_now = h2;
         acc = stb && (adr[14:3] == 12'(BASE / 8)) && !m_ack;
         ri  = adr[2:0];
         n_deb = m_deb;
         if ((n_clk % TP) == TP - 1) begin
            for (int i = 0; i < 4; i++)
               if (m_last_tick[i] == sync_now[i]) n_deb[i] = sync_now[i];
            m_last_tick = sync_now;
         end
         n_clk++;
         w1c  = (acc && we && ri == 3'd5) ? dat_i[3:0] : 4'h0;
         rise = m_deb & ~m_debq & m_ren;
         fall = ~m_deb & m_debq & m_fen;
         if (acc && !we) begin
            if (ri < 3'd4)       m_dat = {16'h0, m_gpo};
            else if (ri == 3'd4) m_dat = {28'h0, m_deb};
            else if (ri == 3'd5) m_dat = {28'h0, m_pend};
            else if (ri == 3'd6) m_dat = {28'h0, m_ren};
            else                 m_dat = {28'h0, m_fen};
         end
         m_irq  = (m_pend != 0);
         m_pend = (m_pend & ~w1c) | rise | fall;
         m_debq = m_deb;
         m_deb  = n_deb;
         if (acc && we) begin
            case (ri)
               3'd0: m_gpo = dat_i[15:0];
               3'd1: m_gpo = m_gpo | dat_i[15:0];
               3'd2: m_gpo = m_gpo & ~dat_i[15:0];
               3'd3: m_gpo = m_gpo ^ dat_i[15:0];
               3'd6: m_ren = dat_i[3:0];
               3'd7: m_fen = dat_i[3:0];
               default: ;
            endcase
         end
         m_ack = acc;
         h2 = h1;
         h1 = gp_i;
      end
   end

   always @(posedge clk) begin
      #1;
      chk("ack_o", {31'h0, ack}, {31'h0, m_ack});
      chk("gp_o",  {16'h0, gp_o}, {16'h0, m_gpo});
      chk("irq_o", {31'h0, irq}, {31'h0, m_irq});
      chk("dat_o", dat_o, m_dat);
   end

   task automatic bus(input logic w, input logic [2:0] r, input logic [31:0] d,
                      output logic [31:0] q);
      logic got;
      @(negedge clk);
      stb = 1'b1; we = w; adr = 15'(BASE + r); dat_i = d;
      got = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (ack) begin got = 1'b1; break; end
      end
      q = dat_o;
      chk("ack_seen", {31'h0, got}, 32'h1);
      @(negedge clk);
      stb = 1'b0; we = 1'b0;
   endtask

   task automatic wr(input logic [2:0] r, input logic [31:0] d);
      logic [31:0] q;
      bus(1'b1, r, d, q);
   endtask

   task automatic rd(input logic [2:0] r, output logic [31:0] q);
      bus(1'b0, r, 32'h0, q);
   endtask

   initial begin
      logic [31:0] q;
      int          acks;
      logic        found;

      repeat (3) @(negedge clk);
      chk("rst_gp_o", {16'h0, gp_o}, {16'h0, INIT});
      chk("rst_irq",  {31'h0, irq}, 32'h0);
      chk("rst_ack",  {31'h0, ack}, 32'h0);
      rst_n = 1'b1;
      rd(3'd4, q); chk("rst_gpi_read", q, 32'h0);

      wr(3'd0, 32'h00F0); wr(3'd1, 32'h0003); wr(3'd2, 32'h0010); wr(3'd3, 32'h8001);
      chk("atomic_gp_o", {16'h0, gp_o}, 32'h80E2);
      rd(3'd0, q); chk("atomic_read", q, 32'h0000_80E2);
      wr(3'd0, 32'hDEAD_80E2);
      rd(3'd1, q); chk("upper_ignored", q, 32'h0000_80E2);

      @(negedge clk); gp_i[0] = 1'b1;
      @(negedge clk); gp_i[0] = 1'b0;
      repeat (12) @(negedge clk);
      rd(3'd4, q); chk("glitch_ignored", q, 32'h0);
      @(negedge clk); gp_i[0] = 1'b1;
      rd(3'd4, q); chk("deb_not_yet", q, 32'h0);
      repeat (9) @(negedge clk);
      rd(3'd4, q); chk("deb_within_11", q, 32'h1);

      wr(3'd6, 32'h1); wr(3'd7, 32'h2);
      @(negedge clk); gp_i[0] = 1'b0;
      repeat (12) @(negedge clk);
      rd(3'd5, q); chk("masked_fall", q, 32'h0);
      gp_i[0] = 1'b1; gp_i[1] = 1'b1;
      repeat (12) @(negedge clk);
      gp_i[1] = 1'b0;
      repeat (12) @(negedge clk);
      rd(3'd5, q); chk("pend_both", q, 32'h3);
      chk("irq_set", {31'h0, irq}, 32'h1);
      wr(3'd5, 32'h1);
      rd(3'd5, q); chk("pend_w1c0", q, 32'h2);
      chk("irq_still", {31'h0, irq}, 32'h1);
      wr(3'd5, 32'h2);
      repeat (2) @(negedge clk);
      chk("irq_clear", {31'h0, irq}, 32'h0);

      gp_i[0] = 1'b0;
      repeat (12) @(negedge clk);
      gp_i[0] = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (m_deb[0] && !m_debq[0]) begin found = 1'b1; break; end
      end
      chk("collision_setup", {31'h0, found}, 32'h1);
      stb = 1'b1; we = 1'b1; adr = 15'(BASE + 5); dat_i = 32'h1;
      @(posedge clk); #1;
      chk("collision_ack", {31'h0, ack}, 32'h1);
      @(negedge clk); stb = 1'b0; we = 1'b0;
      rd(3'd5, q); chk("collision_set_wins", q, 32'h1);

      @(negedge clk);
      stb = 1'b1; we = 1'b1; dat_i = 32'hFFFF_FFFF; adr = 15'(BASE + 8);
      for (int i = 0; i < 3; i++) begin @(posedge clk); #1; chk("no_ack_above", {31'h0, ack}, 32'h0); end
      @(negedge clk); adr = 15'(BASE - 1);
      for (int i = 0; i < 3; i++) begin @(posedge clk); #1; chk("no_ack_below", {31'h0, ack}, 32'h0); end
      @(negedge clk); stb = 1'b0; we = 1'b0;
      rd(3'd0, q); chk("decode_gpo_kept", q, 32'h80E2);
      rd(3'd7, q); chk("decode_fen_kept", q, 32'h2);

      @(negedge clk);
      stb = 1'b1; we = 1'b0; adr = 15'(BASE + 4);
      acks = 0;
      for (int i = 0; i < 4; i++) begin @(posedge clk); #1; if (ack) acks++; end
      @(negedge clk); stb = 1'b0;
      chk("b2b_acks", 32'(acks), 32'd2);

      for (int c = 0; c < 3000; c++) begin
         int unsigned r;
         @(negedge clk);
         if (c == 1500) rst_n = 1'b0;
         if (c == 1503) rst_n = 1'b1;
         stb = 1'($urandom_range(0, 1));
         we  = 1'($urandom_range(0, 1));
         r   = $urandom_range(0, 11);
         if (r < 8)       adr = 15'(BASE + r);
         else if (r < 10) adr = 15'(BASE + 8 + $urandom_range(0, 7));
         else if (r < 11) adr = 15'(BASE - 1);
         else             adr = 15'($urandom);
         dat_i = $urandom;
         if ($urandom_range(0, 9) == 0) gp_i[$urandom_range(0, 3)] ^= 1'b1;
      end
      @(negedge clk); stb = 1'b0;
      repeat (4) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/gpio_hub.md
# gpio_hub

Wishbone-slave general-purpose I/O block and the parametrised successor to the fixed LED/switch port in the board I/O subsystem. It provides GPO_BITS of output with atomic set/clear/toggle and GPI_BITS of input with synchronisation, shared-prescaler debounce, and per-bit edge capture. Edge capture is masked separately for rising and falling edges and is ORed into a level interrupt. It occupies an 8-word window on the 15-bit peripheral address bus, decoded beside the LCD controller.

## Interface
- WIDTH, 32: Wishbone data width; GPO_BITS and GPI_BITS must be ≤ WIDTH.
- GPO_BITS, 16: output bits.
- GPI_BITS, 4: input bits.
- BASE, 24: word address of register 0; must be a multiple of 8.
- TICK_BITS, 16: debounce tick period is 2^TICK_BITS clocks; must be ≥ 1.
- GPO_INIT, 0: reset value of gp_o.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- adr_i  in  15  word address
- dat_i  in  WIDTH  write data
- dat_o  out  WIDTH  read data; registered; unused upper bits are 0
- we_i  in  1  1 = write, 0 = read
- stb_i  in  1  strobe
- ack_o  out  1  acknowledge; registered
- gp_o  out  GPO_BITS  general-purpose outputs
- gp_i  in  GPI_BITS  asynchronous general-purpose inputs
- irq_o  out  1  registered OR of the pending bits

## Operation
- Select: sel = (adr_i[14:3] == BASE>>3). Register index = adr_i[2:0].
- Outside the window the block never asserts ack_o, and it does not modify any state.
- Registers:
  - 0 GPO: read/write.
  - 1 SET: write 1s to set GPO bits; reads GPO.
  - 2 CLR: write 1s to clear GPO bits; reads GPO.
  - 3 TGL: write 1s to invert GPO bits; reads GPO.
  - 4 GPI: read-only debounced inputs; writes ignored.
  - 5 PEND: read pending edge flags; write 1s to clear them.
  - 6 RISE_EN: read/write rising-edge mask.
  - 7 FALL_EN: read/write falling-edge mask.
- Access cycle: when stb_i & sel & ~ack_o, the write commits (if we_i) or dat_o loads the register, and ack_o is 1 on the next clock.
  - ack_o is high for exactly one cycle per access.
  - Back-to-back strobes are acked on alternate cycles.
  - dat_o holds its value until the next access.
- Input path:
  - 2-flop synchroniser per bit gives sync.
  - Free-running TICK_BITS counter; tick = 1 when the counter equals all-ones, then it wraps to 0.
  - On each tick: samp <= sync, and deb[i] <= samp[i] wherever samp[i] == sync[i]. A bit therefore must be equal on two consecutive ticks before deb follows it.
- Edge capture, evaluated every clock:
  - rise = deb & ~deb_q & RISE_EN.
  - fall = ~deb & deb_q & FALL_EN.
  - PEND <= (PEND & ~w1c) | rise | fall.
  - When a set and a W1C clear hit the same bit in the same cycle, the set wins.
  - Clearing a mask bit does not clear an already-pending bit.
- irq_o <= |PEND (one cycle after PEND changes).

## Timing
- Reset values:
  - gp_o = GPO_INIT.
  - dat_o, ack_o, irq_o, PEND, RISE_EN, FALL_EN = 0.
  - sync, samp, deb, deb_q, tick counter = 0.
- Reset asserted mid-access drops ack_o at once; the write commits only if a rising clk edge with rst_n high occurred while stb_i & sel & ~ack_o was true.
- Write to GPO/SET/CLR/TGL: gp_o changes on the same edge that raises ack_o (access edge + 1 from stb).
- Read latency: dat_o is valid while ack_o = 1.
- Debounce latency: a gp_i step held stable reaches deb in 2·2^TICK_BITS + 3 clocks or fewer, and in 2^TICK_BITS + 3 clocks or more.
  - A glitch shorter than 2^TICK_BITS − 2 clocks never changes deb.
- PEND sets 1 clock after deb changes; irq_o follows 1 clock later.
- GPI_BITS or GPO_BITS < WIDTH: reads zero-fill, and writes ignore the upper dat_i bits.

## Test plan
- Reset: hold rst_n low → gp_o = GPO_INIT, irq_o = 0, ack_o = 0. Read reg 4 → 0 with ack after 1 clock.
- Atomic ops (GPO_BITS = 16): write 0x00F0 to reg 0, 0x0003 to SET, 0x0010 to CLR, 0x8001 to TGL → gp_o = 0x80E2, and a read of reg 0 returns 0x000080E2.
- Debounce (TICK_BITS = 2): a 1-clock pulse on gp_i[0] → deb stays 0. Hold gp_i[0] = 1 → reg 4 reads 0x1 within 11 clocks.
- Edges: RISE_EN = 0x1, FALL_EN = 0x2; raise gp_i[0], raise then lower gp_i[1] → PEND = 0x3 and irq_o = 1. Write 0x1 to PEND → PEND = 0x2. Write 0x2 → irq_o = 0.
- Set-vs-clear collision: force a rising edge on bit 0 in the same cycle as a W1C of 0x1 → PEND[0] = 1.
- Decode: stb_i at address BASE+8 and at BASE−1 → no ack_o, no state change. Two back-to-back strobes in the window → exactly 2 single-cycle acks.
